// File: rtl/debtor.sv
// Upstream side of a credit-based link: gates a valid/ready stream on the local
// credit balance and requests more credit with a borrow pulse at a low watermark.
module debtor #(
  parameter int DATA_WIDTH   = 16,
  parameter int WIDTH        = 16,
  parameter int CREDIT_WIDTH = 8,
  parameter int THRESHOLD    = 4,
  parameter int TIMEOUT      = 64,
  parameter int TIMER_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    borrow,
  input  logic                    grant,
  input  logic [CREDIT_WIDTH-1:0] credit,
  output logic [WIDTH-1:0]        balance,
  output logic                    error
);

  // Wide enough that balance plus a full grant can never wrap before saturation.
  localparam int SUM_W = ((WIDTH > CREDIT_WIDTH) ? WIDTH : CREDIT_WIDTH) + 1;
  localparam logic [SUM_W-1:0] BAL_MAX = {{(SUM_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                 state, state_nxt;
  logic [TIMER_WIDTH-1:0] timer, timer_nxt;
  logic [WIDTH-1:0]       bal;
  logic                   err;
  logic                   has_credit;
  logic                   transfer;
  logic [SUM_W-1:0]       sum;
  logic [WIDTH:0]         sat;

  // Returns {overflow, saturated balance}.
  function automatic logic [WIDTH:0] sat_balance(input logic [SUM_W-1:0] s);
    if (s > BAL_MAX) return {1'b1, {WIDTH{1'b1}}};
    else             return {1'b0, s[WIDTH-1:0]};
  endfunction

  assign has_credit = (bal != '0);
  assign out_data   = in_data;
  assign out_valid  = in_valid & has_credit;
  assign in_ready   = out_ready & has_credit;
  assign transfer   = out_valid & out_ready;

  assign sum = SUM_W'(bal) + (grant ? SUM_W'(credit) : '0) - SUM_W'(transfer);
  assign sat = sat_balance(sum);

  assign balance = bal;
  assign error   = err;
  assign borrow  = (state == REQ);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    unique case (state)
      IDLE: begin
        if (!grant && (bal <= WIDTH'(THRESHOLD))) state_nxt = REQ;
      end
      REQ: begin
        timer_nxt = '0;
        state_nxt = grant ? IDLE : WAIT;
      end
      WAIT: begin
        if (grant) begin
          state_nxt = IDLE;
        end else if (TIMEOUT != 0) begin
          if (timer == TIMER_WIDTH'(TIMEOUT - 1)) state_nxt = REQ;
          else                                    timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      bal   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      bal   <= sat[WIDTH-1:0];
      err   <= err | sat[WIDTH];
    end
  end

endmodule

// File: tb/tb_debtor.sv
// Directed bench for debtor: three instances cover default, short-timeout and
// narrow-balance parameterisations, driven from shared stimulus.
module tb_debtor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        grant = 1'b0;
  logic [7:0]  credit = '0;

  logic        in_ready_a, out_valid_a, borrow_a, error_a;
  logic [15:0] out_data_a, balance_a;
  logic        in_ready_b, out_valid_b, borrow_b, error_b;
  logic [15:0] out_data_b, balance_b;
  logic        in_ready_c, out_valid_c, borrow_c, error_c;
  logic [15:0] out_data_c;
  logic [3:0]  balance_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debtor dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .borrow(borrow_a), .grant(grant), .credit(credit), .balance(balance_a), .error(error_a)
  );

  debtor #(.TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .borrow(borrow_b), .grant(grant), .credit(credit), .balance(balance_b), .error(error_b)
  );

  debtor #(.WIDTH(4)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_c),
    .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready),
    .borrow(borrow_c), .grant(grant), .credit(credit), .balance(balance_c), .error(error_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one tick into cycle 0 after reset release.
  task automatic do_reset();
    rst = 1'b1; grant = 1'b0; credit = '0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Reset, then a grant of amt while in WAIT (cycle 2); returns in cycle 3.
  task automatic reset_and_fund(input logic [7:0] amt);
    do_reset();
    step();
    step();
    grant = 1'b1; credit = amt;
    step();
    grant = 1'b0; credit = '0;
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (balance_a !== 16'd0) begin errors++; $display("FAIL rst_balance got %0d exp 0", balance_a); end
    checks++; if (error_a !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", error_a); end
    checks++; if (borrow_a !== 1'b0) begin errors++; $display("FAIL rst_borrow_c0 got %b exp 0", borrow_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid_a); end
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready_a); end
    step();
    checks++; if (borrow_a !== 1'b1) begin errors++; $display("FAIL rst_borrow_c1 got %b exp 1", borrow_a); end
    step();
    checks++; if (borrow_a !== 1'b0) begin errors++; $display("FAIL rst_borrow_c2 got %b exp 0", borrow_a); end
    step();
    checks++; if (borrow_a !== 1'b0) begin errors++; $display("FAIL rst_borrow_c3 got %b exp 0", borrow_a); end
    checks++; if (balance_a !== 16'd0) begin errors++; $display("FAIL rst_no_xfer got %0d exp 0", balance_a); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_stream();
    int xfers = 0;
    int pulses = 0;
    logic [15:0] prev_bal;
    reset_and_fund(8'd10);
    checks++; if (balance_a !== 16'd10) begin errors++; $display("FAIL stream_funded got %0d exp 10", balance_a); end
    out_ready = 1'b1; in_valid = 1'b1;
    prev_bal = balance_a;
    for (int i = 0; i < 12; i++) begin
      in_data = 16'hA000 + 16'(i);
      #1;
      if (out_valid_a && out_ready) begin
        xfers++;
        checks++; if (out_data_a !== in_data) begin errors++; $display("FAIL stream_data got %h exp %h", out_data_a, in_data); end
      end
      if (borrow_a) begin
        pulses++;
        checks++; if (prev_bal !== 16'd4) begin errors++; $display("FAIL stream_borrow_when prev_balance %0d exp 4", prev_bal); end
      end
      prev_bal = balance_a;
      step();
    end
    checks++; if (xfers != 10) begin errors++; $display("FAIL stream_xfers got %0d exp 10", xfers); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL stream_pulses got %0d exp 1", pulses); end
    checks++; if (balance_a !== 16'd0) begin errors++; $display("FAIL stream_final_bal got %0d exp 0", balance_a); end
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL stream_stall_ready got %b exp 0", in_ready_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL stream_stall_valid got %b exp 0", out_valid_a); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic exp;
    do_reset();
    for (int c = 0; c < 31; c++) begin
      exp = (c == 1) || (c == 10) || (c == 19) || (c == 28);
      checks++; if (borrow_b !== exp) begin errors++; $display("FAIL timeout_borrow cycle %0d got %b exp %b", c, borrow_b, exp); end
      step();
    end
  endtask

  task automatic test_grant_and_transfer();
    reset_and_fund(8'd10);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) step();
    in_valid = 1'b0;
    #1;
    checks++; if (borrow_a !== 1'b1) begin errors++; $display("FAIL gt_req_borrow got %b exp 1", borrow_a); end
    step();
    checks++; if (balance_a !== 16'd3) begin errors++; $display("FAIL gt_bal3 got %0d exp 3", balance_a); end
    grant = 1'b1; credit = 8'd5; in_valid = 1'b1;
    #1;
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL gt_out_valid got %b exp 1", out_valid_a); end
    step();
    grant = 1'b0; credit = '0; in_valid = 1'b0;
    checks++; if (balance_a !== 16'd7) begin errors++; $display("FAIL gt_bal7 got %0d exp 7", balance_a); end
    checks++; if (borrow_a !== 1'b0) begin errors++; $display("FAIL gt_no_borrow got %b exp 0", borrow_a); end
    step();
    checks++; if (borrow_a !== 1'b0) begin errors++; $display("FAIL gt_idle_stays got %b exp 0", borrow_a); end
    checks++; if (balance_a !== 16'd7) begin errors++; $display("FAIL gt_bal_hold got %0d exp 7", balance_a); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    reset_and_fund(8'd14);
    checks++; if (balance_c !== 4'd14) begin errors++; $display("FAIL ovf_bal14 got %0d exp 14", balance_c); end
    checks++; if (error_c !== 1'b0) begin errors++; $display("FAIL ovf_err_pre got %b exp 0", error_c); end
    grant = 1'b1; credit = 8'd5;
    step();
    grant = 1'b0; credit = '0;
    checks++; if (balance_c !== 4'd15) begin errors++; $display("FAIL ovf_sat got %0d exp 15", balance_c); end
    checks++; if (error_c !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", error_c); end
    out_ready = 1'b1; in_valid = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (balance_c !== 4'd14) begin errors++; $display("FAIL ovf_drain got %0d exp 14", balance_c); end
    checks++; if (error_c !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", error_c); end
    do_reset();
    checks++; if (error_c !== 1'b0) begin errors++; $display("FAIL ovf_err_clr got %b exp 0", error_c); end
    checks++; if (balance_c !== 4'd0) begin errors++; $display("FAIL ovf_bal_clr got %0d exp 0", balance_c); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    step();
    step();
    rst = 1'b1; grant = 1'b1; credit = 8'd9;
    step();
    rst = 1'b0; grant = 1'b0; credit = '0;
    checks++; if (balance_a !== 16'd0) begin errors++; $display("FAIL rw_bal got %0d exp 0", balance_a); end
    checks++; if (borrow_a !== 1'b0) begin errors++; $display("FAIL rw_borrow_c0 got %b exp 0", borrow_a); end
    step();
    checks++; if (borrow_a !== 1'b1) begin errors++; $display("FAIL rw_borrow_c1 got %b exp 1", borrow_a); end
    checks++; if (balance_a !== 16'd0) begin errors++; $display("FAIL rw_bal_c1 got %0d exp 0", balance_a); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_timeout();
    test_grant_and_transfer();
    test_overflow();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
